// File: rtl/pdp8lbrkarb.sv
// -----------------------------------------------------------------------------
// pdp8lbrkarb -- round-robin arbiter and sequencer for the PDP-8/L data-break
// (DMA) port.
//
// Up to NREQ device interfaces each post a single 12-bit word transfer at a
// 15-bit extended address. One requester is granted at a time. Its address,
// write data and direction are latched. The break request is held toward the
// processor until brkdone, and then a one-cycle ack is returned together with
// the memory word. A watchdog aborts a transfer that the processor never
// finishes. Every abort is flagged with ackerr and counted in errcount.
//
// Ports
//   CLOCK, RESET_N      clock, synchronous active-low reset
//   CSTEP               clock enable for every non-reset state update
//   reqmask, req        per-requester enable and request (held until ack)
//   reqaddr, reqwdata   packed per-requester address (15b) and write data (12b)
//   reqwrite            per-requester direction, 1 = write memory
//   ack, ackerr, rdata  completion pulse, abort flag, returned memory word
//   BRK_RQST/ADDR/DATA/WRITE  break-cycle request bus toward the processor
//   brkgrant, brkdone, memdata  processor break-cycle handshake and data
//   errcount            saturating count of watchdog aborts
//   busy                high whenever a transfer is in progress
// -----------------------------------------------------------------------------
module pdp8lbrkarb #(
    parameter int NREQ     = 3,
    parameter int TMOWIDTH = 10
) (
    input  logic                 CLOCK,
    input  logic                 RESET_N,
    input  logic                 CSTEP,
    input  logic [NREQ-1:0]      reqmask,
    input  logic [NREQ-1:0]      req,
    input  logic [15*NREQ-1:0]   reqaddr,
    input  logic [12*NREQ-1:0]   reqwdata,
    input  logic [NREQ-1:0]      reqwrite,
    output logic [NREQ-1:0]      ack,
    output logic                 ackerr,
    output logic [11:0]          rdata,
    output logic                 BRK_RQST,
    output logic [14:0]          BRK_ADDR,
    output logic [11:0]          BRK_DATA,
    output logic                 BRK_WRITE,
    input  logic                 brkgrant,
    input  logic                 brkdone,
    input  logic [11:0]          memdata,
    output logic [7:0]           errcount,
    output logic                 busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RQST  = 2'd1,
        S_CYCLE = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                state_q,    state_d;
    logic [PW-1:0]         rrptr_q,    rrptr_d;
    logic [PW-1:0]         winner_q,   winner_d;
    logic [14:0]           addr_q,     addr_d;
    logic [11:0]           wdata_q,    wdata_d;
    logic                  write_q,    write_d;
    logic [TMOWIDTH-1:0]   wd_q,       wd_d;
    logic                  ackerr_q,   ackerr_d;
    logic [11:0]           rdata_q,    rdata_d;
    logic [7:0]            errcount_q, errcount_d;

    // Unpack the flat per-requester buses so they can be indexed by winner.
    logic [14:0] addr_arr  [NREQ];
    logic [11:0] wdata_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = reqaddr[15*gi +: 15];
            assign wdata_arr[gi] = reqwdata[12*gi +: 12];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin pick: first eligible index at or above rrptr, wrapping.
    // ------------------------------------------------------------------
    logic [NREQ-1:0] eligible;
    logic            found;
    logic [PW-1:0]   pick;
    logic [PW-1:0]   cand;

    assign eligible = req & reqmask;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int off = 0; off < NREQ; off++) begin
            cand = PW'((int'(rrptr_q) + off) % NREQ);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Watchdog expires on the step whose increment would reach all-ones,
    // so the abort lands 2^TMOWIDTH-1 steps after entering RQST.
    logic [TMOWIDTH-1:0] wd_inc;
    logic                wd_expire;

    assign wd_inc    = wd_q + 1'b1;
    assign wd_expire = &wd_inc;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            rrptr_q    <= '0;
            winner_q   <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            write_q    <= 1'b0;
            wd_q       <= '0;
            ackerr_q   <= 1'b0;
            rdata_q    <= '0;
            errcount_q <= '0;
        end else begin
            state_q    <= state_d;
            rrptr_q    <= rrptr_d;
            winner_q   <= winner_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            write_q    <= write_d;
            wd_q       <= wd_d;
            ackerr_q   <= ackerr_d;
            rdata_q    <= rdata_d;
            errcount_q <= errcount_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic; everything holds while CSTEP is low.
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rrptr_d    = rrptr_q;
        winner_d   = winner_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        write_d    = write_q;
        wd_d       = wd_q;
        ackerr_d   = ackerr_q;
        rdata_d    = rdata_q;
        errcount_d = errcount_q;

        if (CSTEP) begin
            case (state_q)
                S_IDLE: begin
                    if (found) begin
                        winner_d = pick;
                        addr_d   = addr_arr[pick];
                        write_d  = reqwrite[pick];
                        wdata_d  = reqwrite[pick] ? wdata_arr[pick] : 12'd0;
                        rrptr_d  = PW'((int'(pick) + 1) % NREQ);
                        wd_d     = '0;
                        state_d  = S_RQST;
                    end
                end
                S_RQST: begin
                    wd_d = wd_inc;
                    if (brkgrant) begin
                        state_d = S_CYCLE;
                    end else if (wd_expire) begin
                        ackerr_d   = 1'b1;
                        errcount_d = (errcount_q == 8'hFF) ? errcount_q
                                                           : errcount_q + 8'd1;
                        state_d    = S_ACK;
                    end
                end
                S_CYCLE: begin
                    wd_d = wd_inc;
                    // A completing break cycle beats a simultaneous expiry.
                    if (brkdone) begin
                        rdata_d  = memdata;
                        ackerr_d = 1'b0;
                        state_d  = S_ACK;
                    end else if (wd_expire) begin
                        ackerr_d   = 1'b1;
                        errcount_d = (errcount_q == 8'hFF) ? errcount_q
                                                           : errcount_q + 8'd1;
                        state_d    = S_ACK;
                    end
                end
                S_ACK: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded from the registered state.
    // ------------------------------------------------------------------
    logic on_bus;

    always_comb begin
        on_bus    = (state_q == S_RQST) || (state_q == S_CYCLE);
        BRK_RQST  = on_bus;
        BRK_ADDR  = on_bus ? addr_q  : 15'd0;
        BRK_DATA  = on_bus ? wdata_q : 12'd0;
        BRK_WRITE = on_bus & write_q;
        ack       = '0;
        if (state_q == S_ACK) begin
            ack[winner_q] = 1'b1;
        end
        ackerr    = (state_q == S_ACK) & ackerr_q;
        rdata     = rdata_q;
        errcount  = errcount_q;
        busy      = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_pdp8lbrkarb.sv
// -----------------------------------------------------------------------------
// tb_pdp8lbrkarb -- directed sequence with randomized addresses, data and
// handshake delays, checked against a small round-robin reference model.
// -----------------------------------------------------------------------------
module tb_pdp8lbrkarb;

    localparam int NREQ = 3;
    localparam int TMO  = 4;

    logic                CLOCK = 1'b0;
    logic                RESET_N;
    logic                CSTEP;
    logic [NREQ-1:0]     reqmask;
    logic [NREQ-1:0]     req;
    logic [15*NREQ-1:0]  reqaddr;
    logic [12*NREQ-1:0]  reqwdata;
    logic [NREQ-1:0]     reqwrite;
    logic [NREQ-1:0]     ack;
    logic                ackerr;
    logic [11:0]         rdata;
    logic                BRK_RQST;
    logic [14:0]         BRK_ADDR;
    logic [11:0]         BRK_DATA;
    logic                BRK_WRITE;
    logic                brkgrant;
    logic                brkdone;
    logic [11:0]         memdata;
    logic [7:0]          errcount;
    logic                busy;

    pdp8lbrkarb #(.NREQ(NREQ), .TMOWIDTH(TMO)) dut (
        .CLOCK    (CLOCK),
        .RESET_N  (RESET_N),
        .CSTEP    (CSTEP),
        .reqmask  (reqmask),
        .req      (req),
        .reqaddr  (reqaddr),
        .reqwdata (reqwdata),
        .reqwrite (reqwrite),
        .ack      (ack),
        .ackerr   (ackerr),
        .rdata    (rdata),
        .BRK_RQST (BRK_RQST),
        .BRK_ADDR (BRK_ADDR),
        .BRK_DATA (BRK_DATA),
        .BRK_WRITE(BRK_WRITE),
        .brkgrant (brkgrant),
        .brkdone  (brkdone),
        .memdata  (memdata),
        .errcount (errcount),
        .busy     (busy)
    );

    always #5 CLOCK = ~CLOCK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state
    logic [NREQ-1:0] req_v;
    logic [NREQ-1:0] mask_v;
    logic [14:0]     addr_m  [NREQ];
    logic [11:0]     wdata_m [NREQ];
    logic            write_m [NREQ];
    int              rr_m;
    logic [11:0]     rdata_m;
    int              errs_m;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
        cyc++;
    endtask

    task automatic drive_reqs();
        req     = req_v;
        reqmask = mask_v;
        for (int i = 0; i < NREQ; i++) begin
            reqaddr[15*i +: 15]  = addr_m[i];
            reqwdata[12*i +: 12] = wdata_m[i];
            reqwrite[i]          = write_m[i];
        end
    endtask

    task automatic randomize_reqs();
        for (int i = 0; i < NREQ; i++) begin
            addr_m[i]  = 15'($urandom);
            wdata_m[i] = 12'($urandom);
            write_m[i] = 1'($urandom);
        end
        drive_reqs();
    endtask

    // Round-robin rule: first eligible index starting at rr_m, wrapping.
    function automatic int model_pick(input logic [NREQ-1:0] elig);
        for (int k = 0; k < NREQ; k++) begin
            int i = (rr_m + k) % NREQ;
            if (elig[i]) return i;
        end
        return -1;
    endfunction

    // One full transfer, called with the DUT in IDLE. The processor side
    // grants after gdelay idle cycles and finishes after ddelay more.
    task automatic serve(input int gdelay, input int ddelay, input bit scramble,
                         input logic [11:0] md, output int got, output int ack_at);
        logic [14:0]     e_addr;
        logic [11:0]     e_data;
        logic            e_wr;
        logic [NREQ-1:0] e_ack;
        int              exp;
        exp = model_pick(req_v & mask_v);
        check("eligible_exists", (exp >= 0), 1);
        if (exp < 0) exp = 0;
        got    = exp;
        e_addr = addr_m[exp];
        e_wr   = write_m[exp];
        e_data = e_wr ? wdata_m[exp] : 12'd0;
        e_ack  = '0;
        e_ack[exp] = 1'b1;
        rr_m = (exp + 1) % NREQ;

        tick();
        check("brk_rqst_on", BRK_RQST, 1);
        check("brk_addr", BRK_ADDR, e_addr);
        check("brk_write", BRK_WRITE, e_wr);
        check("brk_data", BRK_DATA, e_data);
        check("busy_on", busy, 1);
        if (scramble) randomize_reqs();
        for (int k = 0; k < gdelay; k++) begin
            tick();
            check("rqst_hold", BRK_RQST, 1);
            check("ack_quiet_rqst", ack, 0);
        end
        brkgrant = 1'b1;
        tick();
        brkgrant = 1'b0;
        check("cycle_addr_latched", BRK_ADDR, e_addr);
        check("cycle_data_latched", BRK_DATA, e_data);
        for (int k = 0; k < ddelay; k++) begin
            tick();
            check("cycle_hold", BRK_RQST, 1);
            check("ack_quiet_cycle", ack, 0);
        end
        memdata = md;
        brkdone = 1'b1;
        tick();
        brkdone = 1'b0;
        memdata = 12'($urandom);
        ack_at  = cyc;
        rdata_m = md;
        check("ack_onehot", ack, e_ack);
        check("ackerr_clear", ackerr, 0);
        check("rdata", rdata, rdata_m);
        check("rqst_off_ack", BRK_RQST, 0);
        check("addr_off_ack", BRK_ADDR, 0);
        tick();
        check("ack_one_cycle", ack, 0);
        check("rdata_held", rdata, rdata_m);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=%0d expected=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int got;
        int ack_at;
        int last_ack;
        bit seen1;
        logic [11:0] md;
        logic [NREQ-1:0] e_ack;

        RESET_N  = 1'b0;
        CSTEP    = 1'b1;
        brkgrant = 1'b0;
        brkdone  = 1'b0;
        memdata  = '0;
        req_v    = '0;
        mask_v   = '1;
        rr_m     = 0;
        rdata_m  = '0;
        errs_m   = 0;
        randomize_reqs();

        // Reset state
        repeat (3) tick();
        check("rst_ack", ack, 0);
        check("rst_ackerr", ackerr, 0);
        check("rst_rdata", rdata, 0);
        check("rst_rqst", BRK_RQST, 0);
        check("rst_addr", BRK_ADDR, 0);
        check("rst_data", BRK_DATA, 0);
        check("rst_write", BRK_WRITE, 0);
        check("rst_errcount", errcount, 0);
        check("rst_busy", busy, 0);
        RESET_N = 1'b1;
        tick();
        check("idle_no_req", BRK_RQST, 0);

        // Round-robin, minimum-time handshakes, req held at all ones
        req_v = 3'b111;
        drive_reqs();
        last_ack = 0;
        for (int k = 0; k < 6; k++) begin
            serve(0, 0, 1'b1, 12'($urandom), got, ack_at);
            $display("rr transfer %0d: granted=%0d ack_cycle=%0d", k, got, ack_at);
            check("rr_order", got, k % 3);
            if (k > 0) check("rr_spacing", ack_at - last_ack, 4);
            last_ack = ack_at;
        end

        // Single read from requester 1
        req_v     = 3'b010;
        addr_m[1] = 15'o12345;
        write_m[1] = 1'b0;
        drive_reqs();
        serve(1, 1, 1'b0, 12'o7070, got, ack_at);
        $display("single read: granted=%0d rdata=%0o", got, rdata);
        check("single_idx", got, 1);
        check("single_rdata", rdata, 12'o7070);

        // Mask: requester 1 is never served while masked
        req_v  = 3'b111;
        mask_v = 3'b101;
        randomize_reqs();
        for (int k = 0; k < 4; k++) begin
            serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b1,
                  12'($urandom), got, ack_at);
            $display("masked transfer %0d: granted=%0d", k, got);
            check("mask_not1", (got != 1), 1);
        end
        mask_v = 3'b111;
        drive_reqs();
        seen1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            serve($urandom_range(0, 3), $urandom_range(0, 3), 1'b0,
                  12'($urandom), got, ack_at);
            $display("unmasked transfer %0d: granted=%0d", k, got);
            if (got == 1) seen1 = 1'b1;
        end
        check("unmask_served1", seen1, 1);

        // Watchdog abort: requester 0 alone, brkgrant never arrives
        req_v = 3'b001;
        drive_reqs();
        rr_m = 1;
        tick();
        check("wd_rqst", BRK_RQST, 1);
        for (int k = 1; k < 15; k++) begin
            tick();
            check("wd_no_early_ack", ack, 0);
            check("wd_rqst_hold", BRK_RQST, 1);
        end
        tick();
        errs_m++;
        $display("watchdog abort: ack=%b ackerr=%b errcount=%0d", ack, ackerr, errcount);
        check("wd_ack", ack, 3'b001);
        check("wd_ackerr", ackerr, 1);
        check("wd_errcount", errcount, errs_m);
        check("wd_rdata_kept", rdata, rdata_m);
        check("wd_rqst_off", BRK_RQST, 0);
        req_v = 3'b010;
        drive_reqs();
        tick();
        check("wd_ack_pulse", ack, 0);
        serve(0, 2, 1'b0, 12'($urandom), got, ack_at);
        $display("after abort: granted=%0d", got);
        check("wd_next_served", got, 1);

        // brkdone on the same step the watchdog expires: completion wins
        req_v = 3'b100;
        drive_reqs();
        tick();
        check("sim_rqst", BRK_RQST, 1);
        brkgrant = 1'b1;
        tick();
        brkgrant = 1'b0;
        repeat (13) tick();
        check("sim_no_early_ack", ack, 0);
        md = 12'($urandom);
        memdata = md;
        brkdone = 1'b1;
        tick();
        brkdone = 1'b0;
        rdata_m = md;
        $display("simultaneous: ack=%b ackerr=%b errcount=%0d", ack, ackerr, errcount);
        check("sim_ack", ack, 3'b100);
        check("sim_ackerr", ackerr, 0);
        check("sim_rdata", rdata, rdata_m);
        check("sim_errcount", errcount, errs_m);
        req_v = 3'b000;
        drive_reqs();
        rr_m = 0;
        tick();

        // CSTEP low freezes the sequencer even with brkgrant present
        req_v = 3'b001;
        drive_reqs();
        tick();
        check("frz_rqst", BRK_RQST, 1);
        CSTEP    = 1'b0;
        brkgrant = 1'b1;
        repeat (3) begin
            tick();
            check("frz_hold", BRK_RQST, 1);
            check("frz_no_ack", ack, 0);
        end
        CSTEP    = 1'b1;
        brkgrant = 1'b0;
        brkdone  = 1'b1;
        tick();
        check("frz_still_rqst_no_ack", ack, 0);
        brkdone  = 1'b0;
        brkgrant = 1'b1;
        tick();
        brkgrant = 1'b0;
        md = 12'($urandom);
        memdata = md;
        brkdone = 1'b1;
        tick();
        brkdone = 1'b0;
        rdata_m = md;
        e_ack = 3'b001;
        check("frz_ack", ack, e_ack);
        check("frz_rdata", rdata, rdata_m);
        req_v = 3'b000;
        drive_reqs();
        rr_m = 1;
        tick();

        // Reset in the middle of a break cycle on requester 1
        req_v = 3'b010;
        drive_reqs();
        tick();
        check("mid_rqst", BRK_RQST, 1);
        brkgrant = 1'b1;
        tick();
        brkgrant = 1'b0;
        RESET_N = 1'b0;
        tick();
        check("mid_rqst_off", BRK_RQST, 0);
        check("mid_addr_off", BRK_ADDR, 0);
        check("mid_ack", ack, 0);
        check("mid_busy", busy, 0);
        check("mid_errcount", errcount, 0);
        check("mid_rdata", rdata, 0);
        tick();
        check("mid_ack_late", ack, 0);
        RESET_N = 1'b1;
        rr_m    = 0;
        rdata_m = '0;
        errs_m  = 0;
        req_v   = 3'b111;
        mask_v  = 3'b110;
        drive_reqs();
        serve(0, 0, 1'b0, 12'($urandom), got, ack_at);
        $display("post reset: granted=%0d", got);
        check("post_reset_lowest", got, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
